// File: rtl/video_timing_pkg.sv
// Shared constants, state type and timing helper for the raster timing generator.
package video_timing_pkg;

    // Default 640x480@60 raster
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam logic        DEF_HS_POL   = 1'b0;
    localparam logic        DEF_VS_POL   = 1'b0;
    localparam int unsigned DEF_CNT_W    = 12;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Derived values for one axis: period length and the half-open sync window
    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;
    } timing_t;

    function automatic timing_t f_timing(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        timing_t t;
        t.total      = active + fp + sync + bp;
        t.sync_start = active + fp;
        t.sync_end   = active + fp + sync;
        return t;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Wrap counter for one raster axis with active/sync decode of the next count.
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_nxt,
    output logic             o_wrap,
    output logic             o_active_nxt,
    output logic             o_sync_nxt
);

    localparam timing_t          C_T    = f_timing(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_T.total - 1);
    localparam logic [CNT_W-1:0] C_ACT  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SS   = CNT_W'(C_T.sync_start);
    localparam logic [CNT_W-1:0] C_SE   = CNT_W'(C_T.sync_end);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;
    logic             w_last;

    // Next-count selection and decode; clear wins over step
    always_comb begin
        w_last = (r_cnt == C_LAST);
        w_nxt  = r_cnt;
        if (i_clr) begin
            w_nxt = '0;
        end else if (i_step) begin
            w_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
        end
        o_wrap       = i_step && !i_clr && w_last;
        o_active_nxt = (w_nxt < C_ACT);
        o_sync_nxt   = (w_nxt >= C_SS) && (w_nxt < C_SE);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_nxt = w_nxt;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de/coordinates advanced by pclk_ena.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = DEF_HS_POL,
    parameter logic        VS_POL   = DEF_VS_POL,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pclk_ena,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             sof,
    output logic             eol
);

    localparam logic [CNT_W-1:0] C_H_EOL = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_V_ACT = CNT_W'(V_ACTIVE);

    state_t r_state;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_de;
    logic   r_sof;
    logic   r_eol;

    logic             w_start;
    logic             w_adv;
    logic             w_clr;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_eol;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;

    // Counters are held at zero whenever not running; entry to RUN simply releases the clear
    always_comb begin
        w_start = (r_state == IDLE) && en && pclk_ena;
        w_adv   = (r_state == RUN) && en && pclk_ena;
        w_clr   = !((r_state == RUN) && en);
        w_eol   = (w_start || w_adv) && (w_h_nxt == C_H_EOL) && (w_v_nxt < C_V_ACT);
    end

    video_sync_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_step       (w_adv),
        .o_cnt        (h_cnt),
        .o_nxt        (w_h_nxt),
        .o_wrap       (w_h_wrap),
        .o_active_nxt (w_h_act),
        .o_sync_nxt   (w_h_sync)
    );

    video_sync_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_step       (w_h_wrap),
        .o_cnt        (v_cnt),
        .o_nxt        (w_v_nxt),
        .o_wrap       (w_v_wrap),
        .o_active_nxt (w_v_act),
        .o_sync_nxt   (w_v_sync)
    );

    // IDLE/RUN control with outputs registered from the next-count decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_de    <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sof <= 1'b0;
                    r_eol <= 1'b0;
                    if (w_start) begin
                        r_state <= RUN;
                        r_hsync <= w_h_sync ? HS_POL : ~HS_POL;
                        r_vsync <= w_v_sync ? VS_POL : ~VS_POL;
                        r_de    <= w_h_act && w_v_act;
                        r_sof   <= 1'b1;
                        r_eol   <= w_eol;
                    end else begin
                        r_hsync <= ~HS_POL;
                        r_vsync <= ~VS_POL;
                        r_de    <= 1'b0;
                    end
                end
                RUN: begin
                    r_sof <= 1'b0;
                    r_eol <= 1'b0;
                    if (!en) begin
                        r_state <= IDLE;
                        r_hsync <= ~HS_POL;
                        r_vsync <= ~VS_POL;
                        r_de    <= 1'b0;
                    end else if (pclk_ena) begin
                        r_hsync <= w_h_sync ? HS_POL : ~HS_POL;
                        r_vsync <= w_v_sync ? VS_POL : ~VS_POL;
                        r_de    <= w_h_act && w_v_act;
                        r_sof   <= w_v_wrap;
                        r_eol   <= w_eol;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign sof   = r_sof;
    assign eol   = r_eol;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a small-raster instance share stimulus.
module tb_video_timing_gen;

    localparam int unsigned CW = 12;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          sof;
        logic          eol;
        logic [CW-1:0] h;
        logic [CW-1:0] v;
    } obs_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pclk_ena = 1'b0;
    logic en       = 1'b0;

    logic          a_hs, a_vs, a_de, a_sof, a_eol;
    logic [CW-1:0] a_h, a_v;
    logic          b_hs, b_vs, b_de, b_sof, b_eol;
    logic [CW-1:0] b_h, b_v;

    obs_t obs_a;
    obs_t obs_b;
    assign obs_a = {a_hs, a_vs, a_de, a_sof, a_eol, a_h, a_v};
    assign obs_b = {b_hs, b_vs, b_de, b_sof, b_eol, b_h, b_v};

    video_timing_gen u_def (
        .clk      (clk),
        .rst      (rst),
        .pclk_ena (pclk_ena),
        .en       (en),
        .hsync    (a_hs),
        .vsync    (a_vs),
        .de       (a_de),
        .h_cnt    (a_h),
        .v_cnt    (a_v),
        .sof      (a_sof),
        .eol      (a_eol)
    );

    video_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (5),
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .CNT_W    (CW)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .pclk_ena (pclk_ena),
        .en       (en),
        .hsync    (b_hs),
        .vsync    (b_vs),
        .de       (b_de),
        .h_cnt    (b_h),
        .v_cnt    (b_v),
        .sof      (b_sof),
        .eol      (b_eol)
    );

    always #5 clk = ~clk;

    // Reference raster geometry per instance
    int unsigned ha[2], hfp[2], hsw[2], hbp[2];
    int unsigned va[2], vfp[2], vsw[2], vbp[2];
    bit          hpol[2], vpol[2];

    // Model state: running flag and linear pixel index within the frame
    bit          m_run[2];
    int unsigned m_p[2];

    obs_t q0[$];
    obs_t q1[$];
    bit   started = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic obs_t idle_obs(int d);
        obs_t o;
        o    = '0;
        o.hs = ~hpol[d];
        o.vs = ~vpol[d];
        return o;
    endfunction

    function automatic obs_t model_step(int d, bit r, bit e, bit pe);
        obs_t        o;
        int unsigned ht, vt, h, v;
        bit          moved, first;
        ht    = ha[d] + hfp[d] + hsw[d] + hbp[d];
        vt    = va[d] + vfp[d] + vsw[d] + vbp[d];
        moved = 1'b0;
        first = 1'b0;
        if (r) begin
            m_run[d] = 1'b0;
            m_p[d]   = 0;
        end else if (!m_run[d]) begin
            if (e && pe) begin
                m_run[d] = 1'b1;
                m_p[d]   = 0;
                moved    = 1'b1;
                first    = 1'b1;
            end
        end else if (!e) begin
            m_run[d] = 1'b0;
            m_p[d]   = 0;
        end else if (pe) begin
            m_p[d] = (m_p[d] + 1) % (ht * vt);
            moved  = 1'b1;
            first  = (m_p[d] == 0);
        end
        if (!m_run[d]) return idle_obs(d);
        h     = m_p[d] % ht;
        v     = m_p[d] / ht;
        o.h   = CW'(h);
        o.v   = CW'(v);
        o.de  = (h < ha[d]) && (v < va[d]);
        o.hs  = (h >= ha[d] + hfp[d] && h < ha[d] + hfp[d] + hsw[d]) ? hpol[d] : ~hpol[d];
        o.vs  = (v >= va[d] + vfp[d] && v < va[d] + vfp[d] + vsw[d]) ? vpol[d] : ~vpol[d];
        o.sof = first;
        o.eol = moved && (h == ha[d] - 1) && (v < va[d]);
        return o;
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b de=%b sof=%b eol=%b h=%0d v=%0d, expected hs=%b vs=%b de=%b sof=%b eol=%b h=%0d v=%0d",
                     name, $time, act.hs, act.vs, act.de, act.sof, act.eol, act.h, act.v,
                     exp.hs, exp.vs, exp.de, exp.sof, exp.eol, exp.h, exp.v);
        end
    endtask

    task automatic check_bound(string name, bit reached);
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL %s: got timeout, expected condition reached", name);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected response
    task automatic drive(bit r, bit e, bit pe);
        @(negedge clk);
        rst      = r;
        en       = e;
        pclk_ena = pe;
        q0.push_back(model_step(0, r, e, pe));
        q1.push_back(model_step(1, r, e, pe));
        started = 1'b1;
    endtask

    function automatic bit small_in_vsync();
        int unsigned h, v;
        h = m_p[1] % 31;
        v = m_p[1] / 31;
        return m_run[1] && (v >= 10) && (v < 12) && (h >= 20);
    endfunction

    // Monitor: every rising edge presents one output sample per instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (q0.size() == 0 || q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL queue_underrun t=%0t: got empty queue, expected entry", $time);
                end else begin
                    check("dut_default", obs_a, q0.pop_front());
                    check("dut_small", obs_b, q1.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit reached;
        ha[0] = 640; hfp[0] = 16; hsw[0] = 96; hbp[0] = 48;
        va[0] = 480; vfp[0] = 10; vsw[0] = 2;  vbp[0] = 33;
        hpol[0] = 1'b0; vpol[0] = 1'b0;
        ha[1] = 16;  hfp[1] = 4;  hsw[1] = 6;  hbp[1] = 5;
        va[1] = 8;   vfp[1] = 2;  vsw[1] = 2;  vbp[1] = 3;
        hpol[1] = 1'b1; vpol[1] = 1'b0;
        m_run[0] = 1'b0; m_run[1] = 1'b0;
        m_p[0]   = 0;    m_p[1]   = 0;

        // Reset, then idle with en low and arbitrary pixel enables
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // Pixel enable every other clock
        for (int i = 0; i < 3400; i++) drive(1'b0, 1'b1, 1'(i % 2));

        // Pixel enable held high
        repeat (1700) drive(1'b0, 1'b1, 1'b1);

        // Drop en mid-line at column 300 of the default raster, then restart
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_run[0] && (m_p[0] % 800 == 300)) begin
                reached = 1'b1;
                break;
            end
            drive(1'b0, 1'b1, 1'b1);
        end
        check_bound("reach_h300", reached);
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (40) drive(1'b0, 1'b1, 1'b1);

        // Irregular pixel enable with occasional en drops
        for (int i = 0; i < 4000; i++) begin
            drive(1'b0, ($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0));
        end

        // Async reset while the small raster is in vsync near the end of a line
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (small_in_vsync()) begin
                reached = 1'b1;
                break;
            end
            drive(1'b0, 1'b1, 1'b1);
        end
        check_bound("reach_vsync", reached);
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check("async_rst_default", obs_a, idle_obs(0));
        check("async_rst_small", obs_b, idle_obs(1));
        drive(1'b1, 1'b1, 1'b1);
        repeat (600) drive(1'b0, 1'b1, 1'b1);

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
